// File: rtl/rom_pattern_sequencer_pkg.sv
// Shared types and pattern-table formula for the ROM pattern sequencer.
package rom_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_STEP    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_LOOP    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Untruncated table value; the caller narrows it to the entry width.
  function automatic int rom_entry(input int i, input int seed);
    return seed * (i + 1);
  endfunction

endpackage

// File: rtl/rom_pattern_sequencer_rise_detect.sv
// One-bit registered history with a combinational rising-edge strobe.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/rom_pattern_sequencer.sv
// Pattern table sequencer: direct lookup, single-step, one-shot and looping run,
// with registered address and data outputs.
module rom_pattern_sequencer
  import rom_seq_pkg::*;
#(
  parameter int NBITS_DATA = 4,
  parameter int NBITS_ADDR = 2,
  parameter int DEPTH      = 2 ** NBITS_ADDR,
  parameter int SEED       = 32'h3,
  parameter int TICK_DIV   = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  dir,
  input  logic                  start,
  input  logic                  step,
  input  logic [NBITS_ADDR-1:0] addr_in,
  output logic [NBITS_ADDR-1:0] addr_out,
  output logic [NBITS_DATA-1:0] data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]         TLAST = TW'(TICK_DIV - 1);
  localparam logic [NBITS_ADDR-1:0] LAST  = NBITS_ADDR'(DEPTH - 1);

  logic [NBITS_DATA-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = NBITS_DATA'(rom_entry(g, SEED));
  end

  logic start_rise, step_rise;

  rise_detect u_start_rise (.clk(clk_2), .reset(reset), .sig(start), .rise(start_rise));
  rise_detect u_step_rise  (.clk(clk_2), .reset(reset), .sig(step),  .rise(step_rise));

  function automatic logic [NBITS_ADDR-1:0] advance(input logic [NBITS_ADDR-1:0] a,
                                                    input logic down);
    if (down) return (a == '0)   ? LAST : a - 1'b1;
    else      return (a == LAST) ? '0   : a + 1'b1;
  endfunction

  state_t                state, state_n;
  mode_t                 mode_cur;
  logic [1:0]            mode_p1;
  logic [NBITS_ADDR-1:0] addr_q, addr_n, origin, last_entry;
  logic [NBITS_DATA-1:0] data_q;
  logic [TW-1:0]         tick, tick_n;
  logic                  mode_changed;

  assign mode_cur     = mode_t'(mode);
  assign mode_changed = (mode != mode_p1);
  assign origin       = dir ? LAST : '0;
  // Entry from which a one-shot advance would leave the table.
  assign last_entry   = dir ? '0 : LAST;

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    tick_n  = tick;
    if (mode_cur == MODE_DIRECT) begin
      state_n = IDLE;
      addr_n  = addr_in;
      tick_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (mode_cur == MODE_STEP) begin
            if (step_rise) addr_n = advance(addr_q, dir);
          end else if (start_rise) begin
            state_n = RUN;
            addr_n  = origin;
            tick_n  = '0;
          end
        end
        RUN: begin
          if (mode_changed || (mode_cur == MODE_LOOP && start_rise)) begin
            state_n = IDLE;
            tick_n  = '0;
          end else if (tick == TLAST) begin
            tick_n = '0;
            if (mode_cur == MODE_ONESHOT && addr_q == last_entry) state_n = DONE;
            else                                                  addr_n  = advance(addr_q, dir);
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        DONE: begin
          if (mode_changed) begin
            state_n = IDLE;
            tick_n  = '0;
          end else if (start_rise) begin
            state_n = RUN;
            addr_n  = origin;
            tick_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output register stage: data is looked up from the address being loaded.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      tick    <= '0;
      mode_p1 <= 2'b00;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      data_q  <= rom[addr_n];
      tick    <= tick_n;
      mode_p1 <= mode;
    end
  end

  assign addr_out = addr_q;
  assign data_out = data_q;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_rom_pattern_sequencer.sv
// Self-checking bench: directed tables and sequences plus randomized stimulus
// against a behavioural model of the sequencer rules.
module tb_rom_pattern_sequencer;

  localparam int NA = 2, ND = 4, DEPTH = 4, TD = 4, SEED = 3;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          dir = 1'b0, start = 1'b0, step = 1'b0;
  logic [NA-1:0] addr_in = '0;
  logic [NA-1:0] addr_out;
  logic [ND-1:0] data_out;
  logic          busy, done;

  always #5 clk_2 = ~clk_2;

  rom_pattern_sequencer #(
    .NBITS_DATA(ND), .NBITS_ADDR(NA), .DEPTH(DEPTH), .SEED(SEED), .TICK_DIV(TD)
  ) dut (
    .clk_2(clk_2), .reset(reset), .mode(mode), .dir(dir), .start(start), .step(step),
    .addr_in(addr_in), .addr_out(addr_out), .data_out(data_out), .busy(busy), .done(done)
  );

  int errors = 0, checks = 0;

  // Model: 0 idle, 1 running, 2 finished
  int m_state = 0, m_addr = 0, m_data = 0, m_tick = 0;
  int m_start_q = 0, m_step_q = 0, m_mode_q = 0;

  function automatic int rom_of(int i);
    return (SEED * (i + 1)) % (1 << ND);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int srise, prise, mo, d;
    mo = int'(mode);
    d  = int'(dir);
    if (reset) begin
      m_state = 0; m_addr = 0; m_data = 0; m_tick = 0;
      m_start_q = 0; m_step_q = 0; m_mode_q = 0;
      return;
    end
    srise = (start && m_start_q == 0) ? 1 : 0;
    prise = (step && m_step_q == 0) ? 1 : 0;
    if (mo == 0) begin
      m_addr = int'(addr_in); m_state = 0; m_tick = 0;
    end else if (m_state == 0) begin
      if (mo == 1) begin
        if (prise == 1) m_addr = d ? (m_addr + DEPTH - 1) % DEPTH : (m_addr + 1) % DEPTH;
      end else if (srise == 1) begin
        m_state = 1; m_addr = d ? DEPTH - 1 : 0; m_tick = 0;
      end
    end else if (m_state == 1) begin
      if (mo != m_mode_q || (mo == 3 && srise == 1)) begin
        m_state = 0; m_tick = 0;
      end else if (m_tick == TD - 1) begin
        m_tick = 0;
        if (mo == 2 && m_addr == (d ? 0 : DEPTH - 1)) m_state = 2;
        else m_addr = d ? (m_addr + DEPTH - 1) % DEPTH : (m_addr + 1) % DEPTH;
      end else begin
        m_tick++;
      end
    end else begin
      if (mo != m_mode_q) begin
        m_state = 0; m_tick = 0;
      end else if (srise == 1) begin
        m_state = 1; m_addr = d ? DEPTH - 1 : 0; m_tick = 0;
      end
    end
    m_data = rom_of(m_addr);
    m_start_q = int'(start);
    m_step_q  = int'(step);
    m_mode_q  = mo;
  endtask

  task automatic cyc();
    @(posedge clk_2);
    model_update();
    #1;
    chk("model_addr", 32'(addr_out), 32'(m_addr));
    chk("model_data", 32'(data_out), 32'(m_data));
    chk("model_busy", 32'(busy), 32'(m_state == 1));
    chk("model_done", 32'(done), 32'(m_state == 2));
  endtask

  task automatic pulse_step();
    step = 1'b1; cyc();
    step = 1'b0; cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc();
    start = 1'b0;
  endtask

  typedef struct {
    logic [NA-1:0] a;
    logic [ND-1:0] d;
  } dvec_t;

  dvec_t dv [6];

  initial begin
    dv[0] = '{2'd0, 4'h3}; dv[1] = '{2'd1, 4'h6}; dv[2] = '{2'd2, 4'h9};
    dv[3] = '{2'd3, 4'hC}; dv[4] = '{2'd1, 4'h6}; dv[5] = '{2'd0, 4'h3};

    cyc(); cyc();
    chk("reset_addr", 32'(addr_out), 0);
    chk("reset_data", 32'(data_out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    reset = 1'b0;

    mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      addr_in = dv[i].a;
      start = dv[i].a[0];
      cyc();
      chk("direct_data", 32'(data_out), 32'(dv[i].d));
      chk("direct_addr", 32'(addr_out), 32'(dv[i].a));
      chk("direct_busy", 32'(busy), 0);
      chk("direct_done", 32'(done), 0);
    end
    start = 1'b0;

    mode = 2'b01; dir = 1'b0; cyc();
    for (int k = 1; k <= 3; k++) begin
      pulse_step();
      chk("step_addr", 32'(addr_out), 32'(k));
      chk("step_data", 32'(data_out), 32'(rom_of(k)));
    end
    pulse_step();
    chk("step_wrap_addr", 32'(addr_out), 0);
    chk("step_wrap_data", 32'(data_out), 32'h3);
    step = 1'b1;
    repeat (10) cyc();
    step = 1'b0; cyc();
    chk("step_hold_addr", 32'(addr_out), 1);

    mode = 2'b10; cyc();
    pulse_start();
    chk("os_busy", 32'(busy), 1);
    chk("os_start_addr", 32'(addr_out), 0);
    chk("os_start_data", 32'(data_out), 32'h3);
    for (int a = 1; a <= 3; a++) begin
      repeat (4) cyc();
      chk("os_addr", 32'(addr_out), 32'(a));
      chk("os_data", 32'(data_out), 32'(rom_of(a)));
    end
    repeat (3) cyc();
    chk("os_last_busy", 32'(busy), 1);
    cyc();
    chk("os_done", 32'(done), 1);
    chk("os_done_busy", 32'(busy), 0);
    chk("os_done_data", 32'(data_out), 32'hC);
    repeat (5) cyc();
    chk("os_done_hold", 32'(done), 1);
    chk("os_done_addr", 32'(addr_out), 3);
    pulse_start();
    chk("os_restart_busy", 32'(busy), 1);
    chk("os_restart_data", 32'(data_out), 32'h3);
    chk("os_restart_done", 32'(done), 0);

    mode = 2'b11; dir = 1'b1; cyc();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_addr", 32'(addr_out), 0);
    pulse_start();
    chk("loop_first", 32'(data_out), 32'hC);
    begin
      logic [3:0] seq [5];
      seq[0] = 4'h9; seq[1] = 4'h6; seq[2] = 4'h3; seq[3] = 4'hC; seq[4] = 4'h9;
      for (int i = 0; i < 5; i++) begin
        repeat (4) cyc();
        chk("loop_data", 32'(data_out), 32'(seq[i]));
      end
    end
    pulse_start();
    chk("loop_stop_busy", 32'(busy), 0);
    chk("loop_stop_addr", 32'(addr_out), 2);
    repeat (6) cyc();
    chk("loop_stop_hold", 32'(addr_out), 2);

    pulse_start();
    repeat (2) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midrst_addr", 32'(addr_out), 0);
    chk("midrst_data", 32'(data_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    repeat (8) cyc();
    chk("midrst_still", 32'(addr_out), 0);
    chk("midrst_idle", 32'(busy), 0);

    pulse_start();
    repeat (4) cyc();
    chk("modechg_pre", 32'(addr_out), 2);
    mode = 2'b01; cyc();
    chk("modechg_busy", 32'(busy), 0);
    chk("modechg_addr", 32'(addr_out), 2);
    repeat (3) cyc();
    chk("modechg_hold", 32'(addr_out), 2);

    mode = 2'b10; dir = 1'b0; cyc();
    start = 1'b1; step = 1'b1; cyc();
    start = 1'b0; step = 1'b0;
    chk("sim_busy", 32'(busy), 1);
    chk("sim_addr", 32'(addr_out), 0);
    repeat (4) cyc();
    chk("dirflip_pre", 32'(addr_out), 1);
    dir = 1'b1;
    repeat (4) cyc();
    chk("dirflip_addr", 32'(addr_out), 0);
    chk("dirflip_busy", 32'(busy), 1);
    repeat (4) cyc();
    chk("down_done", 32'(done), 1);
    chk("down_done_addr", 32'(addr_out), 0);

    repeat (3000) begin
      reset   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) start = ~start;
      if ($urandom_range(0, 3) == 0) step = ~step;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      addr_in = NA'($urandom_range(0, DEPTH - 1));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
